// File: rtl/cla_adder_arbiter_if.sv
// Request/response bundle for cla_adder_arbiter: two valid/ready request ports
// and one registered, ID-tagged response port.
interface cla_adder_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_sub;
  logic             req0_lock;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_sub;
  logic             req1_lock;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_sum;
  logic             resp_cout;
  logic             resp_ovf;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub, req0_lock,
    output req1_valid, req1_a, req1_b, req1_sub, req1_lock,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_sum, resp_cout, resp_ovf
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub, req0_lock,
    input  req1_valid, req1_a, req1_b, req1_sub, req1_lock,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_sum, resp_cout, resp_ovf
  );
endinterface

// File: rtl/cla_adder_arbiter.sv
// Round-robin shared 32-bit carry-lookahead adder with registered, ID-tagged response.
// Define ADDER_LOCK_EN to let a requester hold the grant across back-to-back transfers.
module cla_adder_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input logic              clock,
  input logic              reset_n,
  cla_adder_arbiter_if.slave bus
);
  localparam int unsigned NGRP = WIDTH / 8;

  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_next;

  logic             last_grant;
  logic             id_q, cout_q, ovf_q;
  logic [WIDTH-1:0] sum_q;

  logic             can_accept, grant0, grant1, xfer, sel;
  logic [WIDTH-1:0] op_a, op_b, op_bx;
  logic             op_sub;
  logic [WIDTH-1:0] bit_g, bit_p, bit_c, sum;
  logic [NGRP-1:0]  grp_g, grp_p;
  logic [NGRP:0]    grp_c;
  logic             cout, ovf;

`ifdef ADDER_LOCK_EN
  logic locked, lock_owner;
`else
  logic unused_lock;
  assign unused_lock = bus.req0_lock ^ bus.req1_lock;
`endif

  assign can_accept = (state == EMPTY) | bus.resp_ready;

  always_comb begin : arbiter
    grant0 = bus.req0_valid & (!bus.req1_valid | last_grant);
    grant1 = bus.req1_valid & (!bus.req0_valid | !last_grant);
`ifdef ADDER_LOCK_EN
    if (locked) begin
      grant0 = !lock_owner & bus.req0_valid;
      grant1 = lock_owner & bus.req1_valid;
    end
`endif
  end

  assign bus.req0_ready = grant0 & can_accept & reset_n;
  assign bus.req1_ready = grant1 & can_accept & reset_n;
  assign xfer = (bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready);
  assign sel  = grant1;

  assign op_a   = sel ? bus.req1_a   : bus.req0_a;
  assign op_b   = sel ? bus.req1_b   : bus.req0_b;
  assign op_sub = sel ? bus.req1_sub : bus.req0_sub;
  assign op_bx  = op_sub ? ~op_b : op_b;

  // Group carries are each expanded from the carry-in, never chained from the previous group.
  always_comb begin : cla
    logic gg, gp, c;
    gg    = 1'b0;
    gp    = 1'b1;
    c     = 1'b0;
    bit_g = op_a & op_bx;
    bit_p = op_a ^ op_bx;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    bit_c = '0;
    for (int unsigned k = 0; k < NGRP; k++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int unsigned i = 0; i < 8; i++) begin
        gg = bit_g[8*k+i] | (bit_p[8*k+i] & gg);
        gp = gp & bit_p[8*k+i];
      end
      grp_g[k] = gg;
      grp_p[k] = gp;
    end
    grp_c[0] = op_sub;
    for (int unsigned k = 0; k < NGRP; k++) begin
      c = op_sub;
      for (int unsigned j = 0; j <= k; j++) begin
        c = grp_g[j] | (grp_p[j] & c);
      end
      grp_c[k+1] = c;
    end
    for (int unsigned k = 0; k < NGRP; k++) begin
      c = grp_c[k];
      for (int unsigned i = 0; i < 8; i++) begin
        bit_c[8*k+i] = c;
        c = bit_g[8*k+i] | (bit_p[8*k+i] & c);
      end
    end
    sum  = bit_p ^ bit_c;
    cout = grp_c[NGRP];
    ovf  = (op_a[WIDTH-1] == op_bx[WIDTH-1]) & (sum[WIDTH-1] != op_a[WIDTH-1]);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_next;
  end

  always_comb begin : resp_fsm
    state_next = state;
    unique case (state)
      EMPTY: if (xfer) state_next = FULL;
      FULL:  if (bus.resp_ready & !xfer) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (xfer) begin
      last_grant <= sel;
      id_q       <= sel;
      sum_q      <= sum;
      cout_q     <= cout;
      ovf_q      <= ovf;
    end
  end

`ifdef ADDER_LOCK_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      locked     <= 1'b0;
      lock_owner <= 1'b0;
    end else if (xfer) begin
      locked     <= sel ? bus.req1_lock : bus.req0_lock;
      lock_owner <= sel;
    end else if (locked & can_accept & !(lock_owner ? bus.req1_valid : bus.req0_valid)) begin
      locked     <= 1'b0;
    end
  end
`endif

  assign bus.resp_valid = (state == FULL);
  assign bus.resp_id    = id_q;
  assign bus.resp_sum   = sum_q;
  assign bus.resp_cout  = cout_q;
  assign bus.resp_ovf   = ovf_q;
endmodule

// File: tb/tb_cla_adder_arbiter.sv
// Directed-vector bench for cla_adder_arbiter; expected values are hand-computed.
module tb_cla_adder_arbiter;
  logic clock = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  cla_adder_arbiter_if #(.WIDTH(32)) bus ();
  cla_adder_arbiter #(.WIDTH(32)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic lock);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; bus.req0_lock = lock;
  endtask

  task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic lock);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; bus.req1_lock = lock;
  endtask

  // Advance one edge; outputs are then stable and new inputs may be driven.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_resp(input string tag, input logic v, input logic id,
                            input logic [31:0] s);
    check({tag, ".valid"}, {63'd0, bus.resp_valid}, {63'd0, v});
    check({tag, ".id"},    {63'd0, bus.resp_id},    {63'd0, id});
    check({tag, ".sum"},   {32'd0, bus.resp_sum},   {32'd0, s});
  endtask

  task automatic check_ready(input string tag, input logic r0, input logic r1);
    #1;
    check({tag, ".ready0"}, {63'd0, bus.req0_ready}, {63'd0, r0});
    check({tag, ".ready1"}, {63'd0, bus.req1_ready}, {63'd0, r1});
  endtask

  logic [3:0] lock_ids;

  initial begin
    reset_n = 1'b0;
    bus.resp_ready = 1'b1;
    drive0(1'b1, 32'h1, 32'h2, 1'b0, 1'b0);
    drive1(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    check_resp("reset", 1'b0, 1'b0, 32'h0);
    check("reset.cout", {63'd0, bus.resp_cout}, 64'd0);
    check("reset.ovf",  {63'd0, bus.resp_ovf},  64'd0);
    check_ready("reset", 1'b0, 1'b0);

    // First contention after reset goes to requester 0.
    reset_n = 1'b1;
    drive1(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    check_ready("arb0", 1'b1, 1'b0);
    tick();
    check_resp("arb0", 1'b1, 1'b0, 32'h3);
    check("arb0.cout", {63'd0, bus.resp_cout}, 64'd0);
    check_ready("arb1", 1'b0, 1'b1);
    tick();
    check_resp("arb1", 1'b1, 1'b1, 32'h0);
    check("arb1.cout", {63'd0, bus.resp_cout}, 64'd1);
    check("arb1.ovf",  {63'd0, bus.resp_ovf},  64'd0);

    drive1(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive0(1'b1, 32'h8000_0000, 32'h1, 1'b1, 1'b0);
    check_ready("sub", 1'b1, 1'b0);
    tick();
    check_resp("sub", 1'b1, 1'b0, 32'h7FFF_FFFF);
    check("sub.ovf",  {63'd0, bus.resp_ovf},  64'd1);
    check("sub.cout", {63'd0, bus.resp_cout}, 64'd1);
    drive0(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    tick();
    check_resp("addovf", 1'b1, 1'b0, 32'h8000_0000);
    check("addovf.ovf",  {63'd0, bus.resp_ovf},  64'd1);
    check("addovf.cout", {63'd0, bus.resp_cout}, 64'd0);

    // Backpressure: req1 wins (last_grant=0), then the result is held for 4 cycles.
    drive0(1'b1, 32'h10, 32'h20, 1'b0, 1'b0);
    drive1(1'b1, 32'h100, 32'h200, 1'b0, 1'b0);
    check_ready("bp.first", 1'b0, 1'b1);
    tick();
    check_resp("bp.first", 1'b1, 1'b1, 32'h300);
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_ready("bp.hold", 1'b0, 1'b0);
      tick();
      check_resp("bp.hold", 1'b1, 1'b1, 32'h300);
    end
    bus.resp_ready = 1'b1;
    check_ready("bp.release", 1'b1, 1'b0);
    tick();
    check_resp("bp.release", 1'b1, 1'b0, 32'h30);

    // Solo streaming on req1, no bubbles.
    drive0(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive1(1'b1, 32'(i + 1), 32'h10, 1'b0, 1'b0);
      check_ready("stream", 1'b0, 1'b1);
      tick();
      check_resp("stream", 1'b1, 1'b1, 32'(i + 1 + 16));
    end
    drive1(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    check_resp("drain", 1'b0, 1'b1, 32'h15);

    // Reset mid-stream after a req0 transfer: req0 must still win afterwards.
    drive0(1'b1, 32'h5, 32'h5, 1'b0, 1'b0);
    tick();
    check_resp("pre_rst", 1'b1, 1'b0, 32'hA);
    reset_n = 1'b0;
    drive1(1'b1, 32'h200, 32'h0, 1'b0, 1'b0);
    check_ready("in_rst", 1'b0, 1'b0);
    tick();
    check_resp("post_rst", 1'b0, 1'b0, 32'h0);
    reset_n = 1'b1;
    check_ready("post_rst", 1'b1, 1'b0);
    tick();
    check_resp("post_rst.arb", 1'b1, 1'b0, 32'hA);

    // Lock: req1 holds the grant for 3 transfers when the lock feature is built in.
`ifdef ADDER_LOCK_EN
    lock_ids = 4'b0111;
`else
    lock_ids = 4'b0101;
`endif
    drive0(1'b1, 32'h100, 32'h1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive1(1'b1, 32'h200, 32'(k), 1'b0, (k < 2) ? 1'b1 : 1'b0);
      tick();
      check_resp("lock", 1'b1, lock_ids[k], lock_ids[k] ? 32'(32'h200 + k) : 32'h101);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cla_adder_arbiter.md
Name: cla_adder_arbiter

Overview:
- Shares the single 32-bit carry-lookahead adder (built from the 8-bit group G/P generators) between two requesters.
- Requester 0 is the ALU execute path; requester 1 is the iterative multdiv unit.
- Round-robin arbitration with valid/ready handshake on each request port.
- Single registered response stage with backpressure; response tagged with the requester ID.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 8 so the adder decomposes into 8-bit lookahead groups.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  WIDTH  operand A
- req0_b  input  WIDTH  operand B
- req0_sub  input  1  1 = A-B (B inverted, carry-in 1); 0 = A+B
- req0_lock  input  1  hold grant after this transfer (ADDER_LOCK_EN only)
- req1_valid, req1_ready, req1_a, req1_b, req1_sub, req1_lock  same as requester 0, for requester 1
- resp_valid  output  1  response register holds a result
- resp_ready  input  1  consumer accepts the response
- resp_id  output  1  requester the result belongs to
- resp_sum  output  WIDTH  A+B or A-B, modulo 2^WIDTH
- resp_cout  output  1  carry out of the MSB
- resp_ovf  output  1  signed overflow

Behaviour:
- Reset: synchronous. When reset_n=0 at a clock edge:
  - resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0, resp_ovf=0.
  - last_grant=1, so requester 0 wins the first contention.
  - lock_owner cleared.
  - req*_ready is combinational and is 0 whenever reset_n=0.
  - Reset mid-operation discards any held response; no grant is issued during the reset cycle.
- Response register: two states, EMPTY (resp_valid=0) and FULL (resp_valid=1).
- can_accept = !resp_valid | resp_ready.
- Arbitration (combinational, each cycle):
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - Neither valid: no grant.
- reqN_ready = grantN & can_accept & reset_n. At most one ready per cycle.
- Transfer on reqN: at the clock edge where reqN_valid & reqN_ready:
  - resp_sum, resp_cout, resp_ovf and resp_id=N load from the adder.
  - resp_valid goes to 1.
  - last_grant becomes N.
- Latency: exactly 1 cycle from accepted request to resp_valid.
- Throughput: one operation per cycle while resp_ready=1.
- FULL & resp_ready & new transfer: response is replaced in the same edge; resp_valid stays 1.
- FULL & resp_ready & no transfer: resp_valid goes to 0; data outputs hold their last value.
- FULL & !resp_ready: all resp_* outputs hold; both ready outputs are 0; last_grant does not change.
- Arithmetic:
  - sum = A + (sub ? ~B : B) + sub, truncated to WIDTH.
  - cout = carry out of bit WIDTH-1; for subtraction, cout=1 means no borrow.
  - ovf = (A[MSB] == B'[MSB]) & (sum[MSB] != A[MSB]), where B' is the post-inversion operand.
- Adder: combinational carry-lookahead made of WIDTH/8 group G/P blocks plus a group-level carry combine. No ripple between groups.
- Requester inputs may change freely while not accepted; the arbiter never latches an unaccepted request.

Optional Feature:
- Macro: ADDER_LOCK_EN.
- Defined:
  - On a transfer from requester N with reqN_lock=1, lock_owner becomes N.
  - While locked, only requester N may be granted; the other requester sees ready=0 even if valid.
  - The lock is released on the first transfer from N with reqN_lock=0.
  - The lock is also released if reqN_valid=0 in any cycle while can_accept=1.
  - Purpose: lets multdiv issue back-to-back partial-product adds without interleaving.
- Undefined:
  - req*_lock ports exist but are ignored.
  - No lock_owner register; pure round-robin.

Test Plan:
- Reset arbitration: after reset, req0 and req1 both valid (0x00000001+0x00000002, 0xFFFFFFFF+0x00000001), resp_ready=1.
  - Cycle 1: resp_id=0, sum=0x00000003, cout=0.
  - Cycle 2: resp_id=1, sum=0x00000000, cout=1, ovf=0.
- Subtract and overflow:
  - req0 0x80000000 - 0x00000001, sub=1 -> sum=0x7FFFFFFF, ovf=1, cout=1.
  - req0 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, ovf=1, cout=0.
- Backpressure: resp_ready=0 with both requesters valid for 4 cycles.
  - resp_valid=1 with the first result held constant; both ready=0.
  - When resp_ready returns to 1, the other requester is granted the same cycle.
- Solo streaming: req1 alone valid for 5 consecutive cycles with resp_ready=1 -> 5 back-to-back grants to req1, 5 responses, no bubbles.
- Reset mid-stream: reset_n=0 for one edge while resp_valid=1 -> resp_valid=0 the next cycle, and the next contention is won by req0.
- ADDER_LOCK_EN: req1 transfers with lock=1 while req0 is continuously valid.
  - req1 wins 3 consecutive transfers while holding the lock.
  - After req1 drops lock on its 3rd transfer, req0 is granted the next cycle.
  - With the macro undefined, the same stimulus alternates 1,0,1,0.
